// File: rtl/rv_trace_pkg.sv
// Shared types for the commit tracer: record layout, record kinds and store-width codes.
package rv_trace_pkg;

  localparam int TR_CYC_W = 64;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    TR_REG      = 2'b00,
    TR_MEM      = 2'b01,
    TR_MEM_BADW = 2'b10
  } trace_kind_e;

  // cycle is sized for the widest supported stamp; narrower stamps are zero-extended
  typedef struct packed {
    trace_kind_e           kind;
    logic [31:0]           addr;
    logic [31:0]           data;
    logic [TR_CYC_W-1:0]   cycle;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo2w.sv
// Show-ahead record FIFO with two same-edge write ports and one read port.
module trace_fifo2w
  import rv_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk_c,
  input  logic                       rst_c,
  input  logic                       we0_i,
  input  trace_rec_t                 wd0_i,
  input  logic                       we1_i,
  input  trace_rec_t                 wd1_i,
  input  logic                       pop_i,
  output trace_rec_t                 head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);

  trace_rec_t        mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_alt;
  logic [AW:0]       cnt_q, cnt_d;

  // Port 1 lands in the slot after port 0 when both write, keeping REG before MEM
  always_comb begin
    wr_alt   = wr_ptr_q + AW'(we0_i);
    wr_ptr_d = wr_ptr_q + AW'(we0_i) + AW'(we1_i);
    rd_ptr_d = rd_ptr_q + AW'(pop_i);
    cnt_d    = cnt_q + (AW+1)'(we0_i) + (AW+1)'(we1_i) - (AW+1)'(pop_i);
  end

  always_ff @(posedge clk_c or negedge rst_c) begin
    if (!rst_c) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_c) begin
    if (we0_i) mem_q[wr_ptr_q] <= wd0_i;
    if (we1_i) mem_q[wr_alt]   <= wd1_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/rv_commit_tracer.sv
// Commit-trace tap: decodes W-stage register writes and M-stage stores into timestamped
// records, buffers them and streams them out on a valid/ready interface.
module rv_commit_tracer
  import rv_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32,
  parameter int OVF_W = 16
) (
  input  logic              clk_c,
  input  logic              rst_c,
  input  logic              reg_write_w,
  input  logic [4:0]        rd_w,
  input  logic [31:0]       result_w,
  input  logic              mem_write_m,
  input  logic [2:0]        funct3_m,
  input  logic [31:0]       alu_result_m,
  input  logic [31:0]       wd_m,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [31:0]       out_addr,
  output logic [31:0]       out_data,
  output logic [CNT_W-1:0]  out_cycle,
  output logic              full,
  output logic              empty,
  output logic [OVF_W-1:0]  ovf_cnt
);

  localparam int AW = $clog2(DEPTH);

  function automatic logic [OVF_W-1:0] sat_add(input logic [OVF_W-1:0] a, input logic [1:0] b);
    logic [OVF_W:0] s;
    s = {1'b0, a} + (OVF_W+1)'(b);
    return s[OVF_W] ? {OVF_W{1'b1}} : s[OVF_W-1:0];
  endfunction

  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic             ev_reg, ev_mem, acc_reg, acc_mem, pop;
  logic [1:0]       rejected;
  logic [AW:0]      count;
  logic [AW+1:0]    space;
  trace_rec_t       rec_reg, rec_mem, head;

  assign ev_reg = reg_write_w && (rd_w != 5'd0);
  assign ev_mem = mem_write_m;
  assign pop    = out_valid && out_ready;

  always_comb begin
    rec_reg       = '0;
    rec_reg.kind  = TR_REG;
    rec_reg.addr  = {27'b0, rd_w};
    rec_reg.data  = result_w;
    rec_reg.cycle = TR_CYC_W'(cyc_q);

    rec_mem       = '0;
    rec_mem.addr  = alu_result_m;
    rec_mem.cycle = TR_CYC_W'(cyc_q);
    case (funct3_m)
      F3_SB:   begin rec_mem.kind = TR_MEM;      rec_mem.data = {24'b0, wd_m[7:0]};  end
      F3_SH:   begin rec_mem.kind = TR_MEM;      rec_mem.data = {16'b0, wd_m[15:0]}; end
      F3_SW:   begin rec_mem.kind = TR_MEM;      rec_mem.data = wd_m;                end
      default: begin rec_mem.kind = TR_MEM_BADW; rec_mem.data = wd_m;                end
    endcase
  end

  // A same-edge pop frees its slot for this edge's pushes; REG claims space before MEM
  always_comb begin
    space    = (AW+2)'(DEPTH) - {1'b0, count} + (AW+2)'(pop);
    acc_reg  = ev_reg && (space != '0);
    acc_mem  = ev_mem && (space > (AW+2)'(acc_reg));
    rejected = {1'b0, ev_reg && !acc_reg} + {1'b0, ev_mem && !acc_mem};
    cyc_d    = cyc_q + CNT_W'(1);
    ovf_d    = sat_add(ovf_q, rejected);
  end

  always_ff @(posedge clk_c or negedge rst_c) begin
    if (!rst_c) begin
      cyc_q <= '0;
      ovf_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ovf_q <= ovf_d;
    end
  end

  trace_fifo2w #(.DEPTH(DEPTH)) u_fifo (
    .clk_c   (clk_c),
    .rst_c   (rst_c),
    .we0_i   (acc_reg),
    .wd0_i   (rec_reg),
    .we1_i   (acc_mem),
    .wd1_i   (rec_mem),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Storage is not reset, so the head fields are forced to zero while nothing is buffered
  assign out_valid = !empty;
  assign out_kind  = empty ? 2'b00 : head.kind;
  assign out_addr  = empty ? 32'd0 : head.addr;
  assign out_data  = empty ? 32'd0 : head.data;
  assign out_cycle = empty ? '0 : CNT_W'(head.cycle);
  assign ovf_cnt   = ovf_q;

endmodule
